// File: rtl/ulpi_reg_write.sv
// LINK-side ULPI register write sequencer: TXCMD, data byte, STP, with DIR-abort and bounded retry.
// Define ULPI_EXT_ADDR_EN for 8-bit extended register addressing through the 6'h2F escape.
module ulpi_reg_write #(
  parameter logic [1:0]  REG_WRITE_CMD = 2'b10,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WRITE_DATA,
`ifdef ULPI_EXT_ADDR_EN
  input  logic [7:0] ADDR,
`else
  input  logic [5:0] ADDR,
`endif
  input  logic [7:0] DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  input  logic       DIR,
  output logic       STP,
  input  logic       NXT,
  output logic [7:0] ULPI_DATA_OUT
);

`ifdef ULPI_EXT_ADDR_EN
  localparam int unsigned AddrW = 8;
`else
  localparam int unsigned AddrW = 6;
`endif
  localparam logic [3:0] MaxRetry = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTxcmd   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
`ifdef ULPI_EXT_ADDR_EN
    StWaitBus = 3'd4,
    StExtAddr = 3'd5
`else
    StWaitBus = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       retry_q, retry_d;
  logic             ta_q, ta_d;
  logic [7:0]       dout_q, dout_d;
  logic             stp_q, stp_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort;
  logic [7:0]       cmd_start, cmd_lat;
`ifdef ULPI_EXT_ADDR_EN
  logic             ext_start, ext_lat;
`endif

`ifdef ULPI_EXT_ADDR_EN
  // Addresses beyond the 6-bit space (or the escape code itself) go through EXT_ADDR.
  assign ext_start = (ADDR[7:6] != 2'b00) || (ADDR[5:0] == 6'h2F);
  assign ext_lat   = (addr_q[7:6] != 2'b00) || (addr_q[5:0] == 6'h2F);
  assign cmd_start = ext_start ? {REG_WRITE_CMD, 6'h2F} : {REG_WRITE_CMD, ADDR[5:0]};
  assign cmd_lat   = ext_lat ? {REG_WRITE_CMD, 6'h2F} : {REG_WRITE_CMD, addr_q[5:0]};
`else
  assign cmd_start = {REG_WRITE_CMD, ADDR};
  assign cmd_lat   = {REG_WRITE_CMD, addr_q};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;
    ta_d    = ta_q;
    dout_d  = dout_q;
    stp_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;

    case (state_q)
      StIdle: begin
        dout_d = 8'h00;
        if (WRITE_DATA && !DIR) begin
          addr_d  = ADDR;
          data_d  = DATA;
          retry_d = 4'd0;
          ta_d    = 1'b0;
          dout_d  = cmd_start;
          state_d = StTxcmd;
        end
      end
      StTxcmd: begin
        if (DIR) begin
          abort = 1'b1;
        end else if (NXT) begin
`ifdef ULPI_EXT_ADDR_EN
          if (ext_lat) begin
            dout_d  = addr_q;
            state_d = StExtAddr;
          end else begin
            dout_d  = data_q;
            state_d = StData;
          end
`else
          dout_d  = data_q;
          state_d = StData;
`endif
        end
      end
`ifdef ULPI_EXT_ADDR_EN
      StExtAddr: begin
        if (DIR) begin
          abort = 1'b1;
        end else if (NXT) begin
          dout_d  = data_q;
          state_d = StData;
        end
      end
`endif
      StData: begin
        if (DIR) begin
          abort = 1'b1;
        end else if (NXT) begin
          dout_d  = 8'h00;
          stp_d   = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        dout_d  = 8'h00;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StWaitBus: begin
        dout_d = 8'h00;
        // One full DIR-low turnaround cycle must pass before re-driving the bus.
        if (DIR) begin
          ta_d = 1'b0;
        end else if (!ta_q) begin
          ta_d = 1'b1;
        end else begin
          dout_d  = cmd_lat;
          state_d = StTxcmd;
        end
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
        data_d  = 8'h00;
        retry_d = 4'd0;
        ta_d    = 1'b0;
        dout_d  = 8'h00;
      end
    endcase

    if (abort) begin
      dout_d = 8'h00;
      if (retry_q == MaxRetry) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        retry_d = retry_q + 4'd1;
        ta_d    = 1'b0;
        state_d = StWaitBus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= 8'h00;
      retry_q <= 4'd0;
      ta_q    <= 1'b0;
      dout_q  <= 8'h00;
      stp_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      ta_q    <= ta_d;
      dout_q  <= dout_d;
      stp_q   <= stp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BUSY          = (state_q != StIdle);
  assign DONE          = done_q;
  assign ERROR         = err_q;
  assign STP           = stp_q;
  assign ULPI_DATA_OUT = dout_q;

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Table-driven bench for ulpi_reg_write with an expected-output queue; DUT built with MAX_RETRIES=1.
module tb_ulpi_reg_write;

`ifdef ULPI_EXT_ADDR_EN
  localparam int unsigned AW = 8;
`else
  localparam int unsigned AW = 6;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          WRITE_DATA = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic [7:0]    DATA = 8'h00;
  logic          DIR = 1'b0;
  logic          NXT = 1'b0;
  logic          BUSY, DONE, ERROR, STP;
  logic [7:0]    ULPI_DATA_OUT;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ulpi_reg_write #(
    .REG_WRITE_CMD(2'b10),
    .MAX_RETRIES  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WRITE_DATA   (WRITE_DATA),
    .ADDR         (ADDR),
    .DATA         (DATA),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .DIR          (DIR),
    .STP          (STP),
    .NXT          (NXT),
    .ULPI_DATA_OUT(ULPI_DATA_OUT)
  );

  // exp = {busy, done, error, stp, data_out} seen just after the edge that samples the inputs.
  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       dir;
    logic       nxt;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];

  function automatic vec_t mk(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic di, input logic nx,
                              input logic busy, input logic done, input logic err,
                              input logic stp, input logic [7:0] dout);
    vec_t v;
    v.rst = r; v.wr = w; v.addr = a; v.data = d; v.dir = di; v.nxt = nx;
    v.exp = {busy, done, err, stp, dout};
    return v;
  endfunction

  task automatic check(input string tag, input int idx);
    logic [11:0] got, want;
    got  = {BUSY, DONE, ERROR, STP, ULPI_DATA_OUT};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d]: busy/done/err/stp/data got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
               tag, idx, got[11], got[10], got[9], got[8], got[7:0],
               want[11], want[10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rst        = v.rst;
    WRITE_DATA = v.wr;
    ADDR       = v.addr[AW-1:0];
    DATA       = v.data;
    DIR        = v.dir;
    NXT        = v.nxt;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(tag, idx);
  endtask

  initial begin
    logic [7:0] ra, rd;
    bit         seen;

    // reset
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    // basic write 04/45
    vecs.push_back(mk(0, 1, 8'h04, 8'h45, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h45));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    // delayed NXT; a second request while busy is dropped
    vecs.push_back(mk(0, 1, 8'h04, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 1, 8'h3F, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00));
    // abort in DATA, DIR high 5 cycles, turnaround, reissue
    vecs.push_back(mk(0, 1, 8'h04, 8'h45, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h45));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h84));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h45));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00));
    // retry exhaustion: second abort in TXCMD (DIR beats NXT) raises ERROR
    vecs.push_back(mk(0, 1, 8'h0A, 8'h33, 0, 0, 1, 0, 0, 0, 8'h8A));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h8A));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    // start held off by DIR, then reset during DATA
    vecs.push_back(mk(0, 1, 8'h15, 8'h77, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h15, 8'h77, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h15, 8'h77, 0, 0, 1, 0, 0, 0, 8'h95));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h77));
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
`ifdef ULPI_EXT_ADDR_EN
    vecs.push_back(mk(0, 1, 8'h85, 8'h11, 0, 0, 1, 0, 0, 0, 8'hAF));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h85));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h11));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00));
`endif

    foreach (vecs[i]) step(vecs[i], "vec", i);

    // DIR re-asserted during the turnaround cycle restarts the wait
    step(mk(0, 1, 8'h3C, 8'hA5, 0, 0, 1, 0, 0, 0, 8'hBC), "turn", 0);
    step(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00), "turn", 1);
    step(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00), "turn", 2);
    step(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00), "turn", 3);
    step(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00), "turn", 4);
    step(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'hBC), "turn", 5);
    step(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'hA5), "turn", 6);
    step(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00), "turn", 7);
    @(negedge clk);
    NXT  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (DONE && !ERROR) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: got no DONE within 8 cycles, required one DONE pulse");
    end

    // random short-address writes with NXT tied high
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(0, 46));
      rd = 8'($urandom_range(0, 255));
      step(mk(0, 1, ra, rd, 0, 1, 1, 0, 0, 0, {2'b10, ra[5:0]}), "rnd", 4 * k);
      step(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, rd), "rnd", 4 * k + 1);
      step(mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00), "rnd", 4 * k + 2);
      step(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00), "rnd", 4 * k + 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
